// File: rtl/m72_sample_fetch.sv
// m72_sample_fetch: sample-ROM byte server for the sound MCU.
// Two-word buffer (current + prefetch) over a 16-bit req/ack ROM port.
module m72_sample_fetch #(
   parameter int AW         = 16,
   parameter int ADDR_SHIFT = 0
) (
   input  logic          CLK_32M,
   input  logic          reset,
   input  logic [1:0]    sample_addr_wr,
   input  logic [7:0]    sample_addr,
   input  logic          sample_inc,
   output logic [7:0]    sample_rom_data,
   output logic          sample_ready,
   output logic          rom_req,
   output logic [AW-2:0] rom_addr,
   input  logic          rom_ack,
   input  logic [15:0]   rom_data
);

   localparam int TW = AW - 1;
   localparam int WW = (AW > 16 + ADDR_SHIFT) ? AW : 16 + ADDR_SHIFT;

   typedef enum logic [1:0] {IDLE, WAIT_D, WAIT_P} state_t;

   state_t        state, state_n;
   logic [AW-1:0] addr, addr_n;
   logic [7:0]    hi, hi_n, lo, lo_n;
   logic [15:0]   cur_data, cur_data_n, nxt_data, nxt_data_n;
   logic [TW-1:0] cur_tag, cur_tag_n, nxt_tag, nxt_tag_n;
   logic          cur_vld, cur_vld_n, nxt_vld, nxt_vld_n;
   logic          stale, stale_n;
   logic          need_d, issue, ack_ok, outstanding;
   logic [TW-1:0] fetch_tag, new_word;
   logic [WW-1:0] wide;

   assign need_d    = !cur_vld || (cur_tag != addr[AW-1:1]);
   assign fetch_tag = need_d ? addr[AW-1:1] : cur_tag + TW'(1);
   assign issue     = (state == IDLE) && (state_n != IDLE);
   assign ack_ok    = rom_ack && (state != IDLE);

   always_ff @(posedge CLK_32M) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (need_d)       state_n = WAIT_D;
            else if (!nxt_vld) state_n = WAIT_P;
         end
         WAIT_D, WAIT_P: begin
            if (rom_ack) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      rom_req = (state != IDLE);
   end

   // a fetch launched this very cycle also counts as in flight
   assign outstanding = ((state != IDLE) && !rom_ack) || issue;

   always_comb begin
      addr_n     = addr;
      hi_n       = hi;
      lo_n       = lo;
      cur_data_n = cur_data;
      cur_tag_n  = cur_tag;
      cur_vld_n  = cur_vld;
      nxt_data_n = nxt_data;
      nxt_tag_n  = nxt_tag;
      nxt_vld_n  = nxt_vld;
      stale_n    = stale;
      wide       = '0;
      new_word   = '0;
      if (ack_ok) begin
         if (stale) begin
            stale_n = 1'b0;
         end else if (state == WAIT_D) begin
            cur_data_n = rom_data;
            cur_tag_n  = rom_addr;
            cur_vld_n  = 1'b1;
         end else if (cur_vld && (cur_tag + TW'(1)) == rom_addr) begin
            nxt_data_n = rom_data;
            nxt_tag_n  = rom_addr;
            nxt_vld_n  = 1'b1;
         end else if (rom_addr == addr[AW-1:1]) begin
            cur_data_n = rom_data;
            cur_tag_n  = rom_addr;
            cur_vld_n  = 1'b1;
         end
      end
      if (|sample_addr_wr) begin
         if (sample_addr_wr[0]) lo_n = sample_addr;
         if (sample_addr_wr[1]) hi_n = sample_addr;
         wide      = WW'({hi_n, lo_n}) << ADDR_SHIFT;
         addr_n    = wide[AW-1:0];
         cur_vld_n = 1'b0;
         nxt_vld_n = 1'b0;
         if (outstanding) stale_n = 1'b1;
      end else if (sample_inc) begin
         addr_n   = addr + AW'(1);
         new_word = addr_n[AW-1:1];
         if (cur_vld_n && new_word == cur_tag_n) begin
            cur_vld_n = cur_vld_n;
         end else if (nxt_vld_n && new_word == nxt_tag_n) begin
            cur_data_n = nxt_data_n;
            cur_tag_n  = nxt_tag_n;
            cur_vld_n  = 1'b1;
            nxt_vld_n  = 1'b0;
         end else begin
            cur_vld_n = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK_32M) begin
      if (reset) begin
         addr            <= '0;
         hi              <= '0;
         lo              <= '0;
         cur_data        <= '0;
         cur_tag         <= '0;
         cur_vld         <= 1'b0;
         nxt_data        <= '0;
         nxt_tag         <= '0;
         nxt_vld         <= 1'b0;
         stale           <= 1'b0;
         rom_addr        <= '0;
         sample_ready    <= 1'b0;
         sample_rom_data <= '0;
      end else begin
         addr     <= addr_n;
         hi       <= hi_n;
         lo       <= lo_n;
         cur_data <= cur_data_n;
         cur_tag  <= cur_tag_n;
         cur_vld  <= cur_vld_n;
         nxt_data <= nxt_data_n;
         nxt_tag  <= nxt_tag_n;
         nxt_vld  <= nxt_vld_n;
         stale    <= stale_n;
         if (issue) rom_addr <= fetch_tag;
         sample_ready    <= cur_vld_n && (cur_tag_n == addr_n[AW-1:1]);
         sample_rom_data <= addr_n[0] ? cur_data_n[15:8] : cur_data_n[7:0];
      end
   end

endmodule

// File: tb/tb_m72_sample_fetch.sv
// Bench for m72_sample_fetch: ROM responder with programmable latency,
// table of address writes/increments, plus stale-fetch and reset corners.
module tb_m72_sample_fetch;

   logic        CLK_32M;
   logic        reset;
   logic [1:0]  sample_addr_wr;
   logic [7:0]  sample_addr;
   logic        sample_inc;
   logic [7:0]  sample_rom_data;
   logic        sample_ready;
   logic        rom_req;
   logic [14:0] rom_addr;
   logic        rom_ack;
   logic [15:0] rom_data;

   m72_sample_fetch #(.AW(16), .ADDR_SHIFT(0)) dut (
      .CLK_32M(CLK_32M),
      .reset(reset),
      .sample_addr_wr(sample_addr_wr),
      .sample_addr(sample_addr),
      .sample_inc(sample_inc),
      .sample_rom_data(sample_rom_data),
      .sample_ready(sample_ready),
      .rom_req(rom_req),
      .rom_addr(rom_addr),
      .rom_ack(rom_ack),
      .rom_data(rom_data)
   );

   initial begin
      CLK_32M = 1'b0;
      forever #5 CLK_32M = ~CLK_32M;
   end

   int          nchk;
   int          nerr;
   int          lat;
   logic        stray;
   logic [14:0] req_log[$];

   function automatic logic [15:0] mem(input logic [14:0] w);
      if (w == 15'h0000)      mem = 16'hA155;
      else if (w == 15'h0108) mem = 16'hBBAA;
      else if (w == 15'h0109) mem = 16'hDDCC;
      else                    mem = {w[7:0] ^ 8'h80, w[7:0]};
   endfunction

   // ROM port model, acting just after each rising edge
   initial begin
      int wcnt;
      wcnt     = 0;
      rom_ack  = 1'b0;
      rom_data = 16'h0000;
      forever begin
         @(posedge CLK_32M);
         #1;
         rom_ack = 1'b0;
         if (stray) begin
            rom_ack  = 1'b1;
            rom_data = 16'hDEAD;
         end else if (rom_req) begin
            if (wcnt >= lat) begin
               rom_ack  = 1'b1;
               rom_data = mem(rom_addr);
               req_log.push_back(rom_addr);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pulse(input logic [1:0] wr, input logic [7:0] ab, input logic inc);
      @(negedge CLK_32M);
      sample_addr_wr = wr;
      sample_addr    = ab;
      sample_inc     = inc;
      @(negedge CLK_32M);
      sample_addr_wr = 2'b00;
      sample_inc     = 1'b0;
   endtask

   task automatic wait_ready(input string nm, input int budget);
      int n;
      n = 0;
      while (!sample_ready && n < budget) begin
         @(negedge CLK_32M);
         n++;
      end
      if (!sample_ready) begin
         nchk++;
         nerr++;
         $display("FAIL %s: sample_ready still 0 after %0d cycles", nm, budget);
      end
   endtask

   task automatic log_at(input string nm, input int idx, input logic [14:0] exp);
      if (req_log.size() > idx) chk(nm, 32'(req_log[idx]), 32'(exp));
      else chk(nm, 32'(req_log.size()), 32'(idx + 1));
   endtask

   typedef struct {
      logic [1:0] wr;
      logic [7:0] ab;
      logic       inc;
      logic       hit;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int n0;
      int n;
      tbl[0]  = '{2'b01, 8'h10, 1'b0, 1'b0, 8'h08};
      tbl[1]  = '{2'b10, 8'h02, 1'b0, 1'b0, 8'hAA};
      tbl[2]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'hBB};
      tbl[3]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'hCC};
      tbl[4]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'hDD};
      tbl[5]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'h0A};
      tbl[6]  = '{2'b11, 8'h12, 1'b1, 1'b0, 8'h09};
      tbl[7]  = '{2'b01, 8'hFF, 1'b0, 1'b0, 8'hFF};
      tbl[8]  = '{2'b10, 8'hFF, 1'b0, 1'b0, 8'h7F};
      tbl[9]  = '{2'b00, 8'h00, 1'b1, 1'b1, 8'h55};
      tbl[10] = '{2'b00, 8'h00, 1'b1, 1'b1, 8'hA1};

      nchk           = 0;
      nerr           = 0;
      lat            = 0;
      stray          = 1'b0;
      reset          = 1'b1;
      sample_addr_wr = 2'b00;
      sample_addr    = 8'h00;
      sample_inc     = 1'b0;

      repeat (3) @(negedge CLK_32M);
      chk("rst_ready", 32'(sample_ready), 32'd0);
      chk("rst_data", 32'(sample_rom_data), 32'd0);
      chk("rst_req", 32'(rom_req), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      reset = 1'b0;

      wait_ready("boot_ready", 20);
      chk("boot_data", 32'(sample_rom_data), 32'h55);
      log_at("boot_req0", 0, 15'h0000);
      n = 0;
      while (req_log.size() < 2 && n < 20) begin
         @(negedge CLK_32M);
         n++;
      end
      log_at("boot_prefetch", 1, 15'h0001);

      for (int i = 0; i < 11; i++) begin
         pulse(tbl[i].wr, tbl[i].ab, tbl[i].inc);
         chk($sformatf("v%0d_ready_after_pulse", i), 32'(sample_ready), 32'(tbl[i].hit));
         wait_ready($sformatf("v%0d_wait", i), 40);
         chk($sformatf("v%0d_data", i), 32'(sample_rom_data), 32'(tbl[i].exp));
         repeat (8) @(negedge CLK_32M);
      end

      // address write while a slow prefetch is in flight
      lat = 10;
      pulse(2'b01, 8'h40, 1'b0);
      chk("slow_miss_ready", 32'(sample_ready), 32'd0);
      wait_ready("slow_miss_wait", 80);
      chk("slow_miss_data", 32'(sample_rom_data), 32'hA0);
      repeat (3) @(negedge CLK_32M);
      chk("pf_req", 32'(rom_req), 32'd1);
      chk("pf_addr", 32'(rom_addr), 32'h7FA1);
      n0 = req_log.size();
      pulse(2'b10, 8'h20, 1'b0);
      chk("stale_ready0", 32'(sample_ready), 32'd0);
      wait_ready("stale_wait", 80);
      chk("stale_ack_count", 32'(req_log.size() - n0), 32'd2);
      log_at("stale_old", n0, 15'h7FA1);
      log_at("stale_new", n0 + 1, 15'h1020);
      chk("stale_data", 32'(sample_rom_data), 32'h20);
      repeat (4) @(negedge CLK_32M);

      // reset while a demand fetch is outstanding
      pulse(2'b01, 8'h44, 1'b0);
      n = 0;
      while (!rom_req && n < 10) begin
         @(negedge CLK_32M);
         n++;
      end
      chk("mid_req_up", 32'(rom_req), 32'd1);
      reset = 1'b1;
      @(negedge CLK_32M);
      chk("mid_rst_req", 32'(rom_req), 32'd0);
      chk("mid_rst_ready", 32'(sample_ready), 32'd0);
      chk("mid_rst_data", 32'(sample_rom_data), 32'd0);
      lat   = 0;
      stray = 1'b1;
      @(negedge CLK_32M);
      n0    = req_log.size();
      reset = 1'b0;
      stray = 1'b0;
      @(negedge CLK_32M);
      chk("stray_ready", 32'(sample_ready), 32'd0);
      chk("fresh_req", 32'(rom_req), 32'd1);
      chk("fresh_addr", 32'(rom_addr), 32'd0);
      wait_ready("fresh_wait", 20);
      chk("fresh_data", 32'(sample_rom_data), 32'h55);
      log_at("fresh_log", n0, 15'h0000);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
